poly_result_checker: RTL

Downstream self-check stage for the cubic-polynomial register stage. It samples the stage's registered operand and registered result each cycle and recomputes the expected value x³ + x² + x internally. After aligning the operand to the result latency, it compares the two and counts mismatches over a programmable run length. It sits directly after the polynomial stage in the bring-up/test harness and reports pass/fail plus first-failure debug data.

---
 rtl/poly_result_checker_if.sv | 16 +
 rtl/poly_result_checker.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/poly_result_checker_if.sv
// Upstream data bus between the cubic-polynomial stage and its checker.
// Signals:
//   in_valid  - in_sample carries a new operand this cycle
//   in_sample - registered operand of the polynomial stage
//   in_result - registered result of the polynomial stage
// Modports: master (polynomial stage / driver), slave (checker).
interface poly_result_checker_if #(
    parameter int unsigned WIDTH = 8
);
    logic             in_valid;
    logic [WIDTH-1:0] in_sample;
    logic [WIDTH-1:0] in_result;

    modport master (output in_valid, output in_sample, output in_result);
    modport slave  (input  in_valid, input  in_sample, input  in_result);
endinterface

// File: rtl/poly_result_checker.sv
// Self-check stage for the cubic-polynomial register stage. Recomputes
// x^3 + x^2 + x for each valid operand, aligns it to the upstream result
// latency, compares, and counts checks/mismatches over a programmed run.
// Ports:
//   clk, rst          - rising-edge clock, synchronous active-high reset
//   start             - begin a run (honoured in IDLE or DONE only)
//   num_samples       - run length, latched on start
//   up                - upstream bus (in_valid, in_sample, in_result)
//   busy, done, pass  - run status
//   err_count         - mismatches this run (saturating)
//   checked           - comparisons this run
//   first_err_*       - first-mismatch capture
// Optional feature: define POLY_CHK_CAPTURE_EN to build the first-mismatch
// capture registers; otherwise first_err_* are tied to zero.
module poly_result_checker #(
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned LATENCY = 1,
    parameter int unsigned CNT_W   = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [CNT_W-1:0]      num_samples,
    poly_result_checker_if.slave  up,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [CNT_W-1:0]      err_count,
    output logic [CNT_W-1:0]      checked,
    output logic [WIDTH-1:0]      first_err_sample,
    output logic [WIDTH-1:0]      first_err_expected,
    output logic [WIDTH-1:0]      first_err_actual
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e                          state_q, state_d;
    logic [CNT_W-1:0]                target_q, target_d;
    logic [CNT_W-1:0]                checked_q, checked_d;
    logic [CNT_W-1:0]                err_q, err_d;
    logic                            busy_q, busy_d;
    logic                            done_q, done_d;
    logic                            pass_q, pass_d;
    logic [LATENCY-1:0]              pv_q, pv_d;
    logic [LATENCY-1:0][WIDTH-1:0]   ps_q, ps_d;

    logic [WIDTH-1:0]                aligned_c;
    logic [WIDTH-1:0]                sq_c;
    logic [WIDTH-1:0]                cube_c;
    logic [WIDTH-1:0]                expected_c;
    logic                            cmp_c;
    logic                            mismatch_c;
    logic                            start_acc_c;

    // Expected value; low WIDTH bits of a product depend only on the low
    // WIDTH bits of its operands, so WIDTH-bit arithmetic equals the
    // full-width result truncated.
    always_comb begin
        aligned_c  = ps_q[LATENCY-1];
        sq_c       = aligned_c * aligned_c;
        cube_c     = sq_c * aligned_c;
        expected_c = cube_c + sq_c + aligned_c;
    end

    always_comb begin
        cmp_c       = (state_q == RUN) && pv_q[LATENCY-1];
        mismatch_c  = cmp_c && (expected_c != up.in_result);
        start_acc_c = start && (state_q != RUN);
    end

    // Next-state, counters and alignment pipe.
    always_comb begin
        state_d   = state_q;
        target_d  = target_q;
        checked_d = checked_q;
        err_d     = err_q;
        pv_d      = '0;
        ps_d      = '0;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    target_d  = num_samples;
                    checked_d = '0;
                    err_d     = '0;
                    state_d   = (num_samples == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (cmp_c) begin
                    checked_d = checked_q + CNT_W'(1);
                    if (mismatch_c && (err_q != '1)) begin
                        err_d = err_q + CNT_W'(1);
                    end
                    if (checked_d == target_q) begin
                        state_d = DONE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Pipe only advances while staying in RUN; entering or leaving RUN
        // flushes it so stale operands never produce a compare.
        if ((state_q == RUN) && (state_d == RUN)) begin
            for (int i = LATENCY - 1; i > 0; i--) begin
                pv_d[i] = pv_q[i-1];
                ps_d[i] = ps_q[i-1];
            end
            pv_d[0] = up.in_valid;
            ps_d[0] = up.in_sample;
        end

        busy_d = (state_d == RUN);
        done_d = (state_d == DONE);
        pass_d = done_d && (err_d == '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            target_q  <= '0;
            checked_q <= '0;
            err_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            pass_q    <= 1'b0;
            pv_q      <= '0;
            ps_q      <= '0;
        end else begin
            state_q   <= state_d;
            target_q  <= target_d;
            checked_q <= checked_d;
            err_q     <= err_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            pass_q    <= pass_d;
            pv_q      <= pv_d;
            ps_q      <= ps_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign pass      = pass_q;
    assign err_count = err_q;
    assign checked   = checked_q;

`ifdef POLY_CHK_CAPTURE_EN
    logic             fe_hit_q, fe_hit_d;
    logic [WIDTH-1:0] fe_s_q, fe_s_d;
    logic [WIDTH-1:0] fe_e_q, fe_e_d;
    logic [WIDTH-1:0] fe_a_q, fe_a_d;

    // Latch only the first mismatch of a run; cleared by an accepted start.
    always_comb begin
        fe_hit_d = fe_hit_q;
        fe_s_d   = fe_s_q;
        fe_e_d   = fe_e_q;
        fe_a_d   = fe_a_q;
        if (start_acc_c) begin
            fe_hit_d = 1'b0;
            fe_s_d   = '0;
            fe_e_d   = '0;
            fe_a_d   = '0;
        end else if (mismatch_c && !fe_hit_q) begin
            fe_hit_d = 1'b1;
            fe_s_d   = aligned_c;
            fe_e_d   = expected_c;
            fe_a_d   = up.in_result;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fe_hit_q <= 1'b0;
            fe_s_q   <= '0;
            fe_e_q   <= '0;
            fe_a_q   <= '0;
        end else begin
            fe_hit_q <= fe_hit_d;
            fe_s_q   <= fe_s_d;
            fe_e_q   <= fe_e_d;
            fe_a_q   <= fe_a_d;
        end
    end

    assign first_err_sample   = fe_s_q;
    assign first_err_expected = fe_e_q;
    assign first_err_actual   = fe_a_q;
`else
    logic unused_c;
    assign unused_c           = start_acc_c;
    assign first_err_sample   = '0;
    assign first_err_expected = '0;
    assign first_err_actual   = '0;
`endif

endmodule
